uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_pkg.sv | 73 +++++++
 rtl/uart_transmitter.sv | 182 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// uart_transmitter_pkg
// Shared UART definitions used by the transmitter and the receiver:
//   - uart_state_e  : serial FSM state encoding
//   - WLEN_*        : word-length codes carried on wlen_i
//   - TICK_LAST     : last value of the 16x oversampling tick counter
//   - helpers for word-length decoding, parity and line forcing
// ---------------------------------------------------------------------------
package uart_transmitter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } uart_state_e;

   localparam logic [1:0] WLEN_5 = 2'b00;
   localparam logic [1:0] WLEN_6 = 2'b01;
   localparam logic [1:0] WLEN_7 = 2'b10;
   localparam logic [1:0] WLEN_8 = 2'b11;

   // Each serial bit spans 16 enable ticks; the counter wraps 15 -> 0.
   localparam logic [3:0] TICK_LAST = 4'd15;

   // Index of the final data bit for a word-length code.
   function automatic logic [2:0] last_data_idx(input logic [1:0] wlen);
      logic [2:0] idx;
      case (wlen)
         WLEN_5:  idx = 3'd4;
         WLEN_6:  idx = 3'd5;
         WLEN_7:  idx = 3'd6;
         WLEN_8:  idx = 3'd7;
         default: idx = 3'd7;
      endcase
      return idx;
   endfunction

   // Mask selecting the data bits that belong to the word.
   function automatic logic [7:0] data_mask(input logic [1:0] wlen);
      logic [7:0] mask;
      case (wlen)
         WLEN_5:  mask = 8'h1F;
         WLEN_6:  mask = 8'h3F;
         WLEN_7:  mask = 8'h7F;
         WLEN_8:  mask = 8'hFF;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // Parity bit: stick mode drives the inverse of the even select, otherwise
   // even select yields the XOR of the word and odd select its inverse.
   function automatic logic calc_parity(input logic [7:0] dat,
                                        input logic [1:0] wlen,
                                        input logic       even,
                                        input logic       stick);
      logic x;
      x = ^(dat & data_mask(wlen));
      if (stick) begin
         return ~even;
      end
      return even ? x : ~x;
   endfunction

   // Break overrides whatever level the FSM wants on the line.
   function automatic logic line_level(input logic brk, input logic lvl);
      return brk ? 1'b0 : lvl;
   endfunction

endpackage

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// Serial UART transmitter with a one-entry holding register, 5..8 data bits,
// optional normal/stick parity, one or two stop bits and line break.
//
// Parameters
//   Tp          register-assignment delay (kept for interface compatibility)
//   init_value  idle level of stx_o
//
// Ports
//   clk_i        in   clock
//   rst_i        in   asynchronous active-low reset
//   enable_i     in   16x baud tick, one-cycle pulse
//   wlen_i       in   word length: 00=5, 01=6, 10=7, 11=8 bits
//   stop2_i      in   0 = one stop bit, 1 = two stop bits
//   par_en_i     in   parity bit enable
//   par_even_i   in   even parity select
//   par_stick_i  in   stick parity
//   break_i      in   force serial line low
//   tx_dat_i     in   character to send
//   tx_valid_i   in   character offered
//   tx_ready_o   out  holding register empty
//   stx_o        out  serial line (registered)
//   busy_o       out  shifter not idle
//   tx_empty_o   out  holding register empty and shifter idle
// ---------------------------------------------------------------------------
module uart_transmitter
   import uart_transmitter_pkg::*;
#(
   parameter int   Tp         = 1,
   parameter logic init_value = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic [1:0] wlen_i,
   input  logic       stop2_i,
   input  logic       par_en_i,
   input  logic       par_even_i,
   input  logic       par_stick_i,
   input  logic       break_i,
   input  logic [7:0] tx_dat_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       stx_o,
   output logic       busy_o,
   output logic       tx_empty_o
);

   uart_state_e r_state;
   logic [3:0]  r_tick;
   logic        r_hold_full;
   logic [7:0]  r_hold_dat;
   logic [7:0]  r_shift;
   logic [2:0]  r_bitcnt;
   logic [2:0]  r_last_idx;
   logic        r_par_en;
   logic        r_par;
   logic        r_stop2;
   logic        r_bit;   // level the FSM wants on the line, before break
   logic        r_stx;

   logic w_accept;
   logic w_load;
   logic w_unused_tp;

   // Tp has no effect on synthesised timing.
   assign w_unused_tp = (Tp != 0);

   assign w_accept = tx_valid_i & ~r_hold_full;
   assign w_load   = enable_i & r_hold_full & (r_state == ST_IDLE);

   // Holding register. Accept and load are mutually exclusive because
   // accept needs an empty register and load needs a full one.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_hold_full <= 1'b0;
         r_hold_dat  <= '0;
      end else if (w_accept) begin
         r_hold_full <= 1'b1;
         r_hold_dat  <= tx_dat_i;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end
   end

   // Serial FSM. r_stx defaults to the current bit level (so a change of
   // break_i shows up next cycle) and is overridden with the new level on
   // every bit boundary so the line tracks the state without extra latency.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= ST_IDLE;
         r_tick     <= '0;
         r_shift    <= '0;
         r_bitcnt   <= '0;
         r_last_idx <= '0;
         r_par_en   <= 1'b0;
         r_par      <= 1'b0;
         r_stop2    <= 1'b0;
         r_bit      <= init_value;
         r_stx      <= init_value;
      end else begin
         r_stx <= line_level(break_i, r_bit);

         if (w_load) begin
            // Framing controls are captured here and held for the character.
            r_state    <= ST_START;
            r_tick     <= '0;
            r_shift    <= r_hold_dat;
            r_bitcnt   <= '0;
            r_last_idx <= last_data_idx(wlen_i);
            r_par_en   <= par_en_i;
            r_par      <= calc_parity(r_hold_dat, wlen_i, par_even_i, par_stick_i);
            r_stop2    <= stop2_i;
            r_bit      <= 1'b0;
            r_stx      <= line_level(break_i, 1'b0);
         end else if (enable_i && (r_state != ST_IDLE)) begin
            r_tick <= r_tick + 4'd1;

            if (r_tick == TICK_LAST) begin
               case (r_state)
                  ST_START: begin
                     r_state <= ST_DATA;
                     r_bit   <= r_shift[0];
                     r_stx   <= line_level(break_i, r_shift[0]);
                  end

                  ST_DATA: begin
                     if (r_bitcnt == r_last_idx) begin
                        if (r_par_en) begin
                           r_state <= ST_PARITY;
                           r_bit   <= r_par;
                           r_stx   <= line_level(break_i, r_par);
                        end else begin
                           r_state <= ST_STOP1;
                           r_bit   <= 1'b1;
                           r_stx   <= line_level(break_i, 1'b1);
                        end
                     end else begin
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        r_bit    <= r_shift[1];
                        r_stx    <= line_level(break_i, r_shift[1]);
                     end
                  end

                  ST_PARITY: begin
                     r_state <= ST_STOP1;
                     r_bit   <= 1'b1;
                     r_stx   <= line_level(break_i, 1'b1);
                  end

                  ST_STOP1: begin
                     if (r_stop2) begin
                        r_state <= ST_STOP2;
                        r_bit   <= 1'b1;
                        r_stx   <= line_level(break_i, 1'b1);
                     end else begin
                        r_state <= ST_IDLE;
                        r_bit   <= init_value;
                        r_stx   <= line_level(break_i, init_value);
                     end
                  end

                  default: begin
                     // ST_STOP2 and any unreachable encoding return to idle.
                     r_state <= ST_IDLE;
                     r_bit   <= init_value;
                     r_stx   <= line_level(break_i, init_value);
                  end
               endcase
            end
         end
      end
   end

   assign tx_ready_o = ~r_hold_full;
   assign busy_o     = (r_state != ST_IDLE);
   assign tx_empty_o = ~r_hold_full & (r_state == ST_IDLE);
   assign stx_o      = r_stx;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
// Scoreboard bench: each offered character pushes its expected serial frame;
// a line monitor pops a frame on every start bit and checks each bit at its
// middle tick, the return to idle and the frame length.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

   typedef struct {
      logic [11:0] bits;
      int unsigned n;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       enable_i;
   logic [1:0] wlen_i;
   logic       stop2_i;
   logic       par_en_i;
   logic       par_even_i;
   logic       par_stick_i;
   logic       break_i;
   logic [7:0] tx_dat_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic       stx_o;
   logic       busy_o;
   logic       tx_empty_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   frame_t      sb[$];
   logic        mon_en       = 1'b1;
   int unsigned frames_done  = 0;
   int unsigned last_len     = 0;
   int unsigned last_gap     = 0;
   int unsigned last_end_cyc = 0;
   int unsigned cyc          = 0;

   int unsigned en_period = 1;
   logic        en_pause  = 1'b0;
   int unsigned en_cnt    = 0;

   uart_transmitter #(
      .Tp         (1),
      .init_value (1'b1)
   ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .wlen_i      (wlen_i),
      .stop2_i     (stop2_i),
      .par_en_i    (par_en_i),
      .par_even_i  (par_even_i),
      .par_stick_i (par_stick_i),
      .break_i     (break_i),
      .tx_dat_i    (tx_dat_i),
      .tx_valid_i  (tx_valid_i),
      .tx_ready_o  (tx_ready_o),
      .stx_o       (stx_o),
      .busy_o      (busy_o),
      .tx_empty_o  (tx_empty_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected frame: start, data LSB first, optional parity, stop bit(s).
   function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] wl,
                                         input logic pe, input logic ev,
                                         input logic st, input logic s2);
      frame_t      f;
      int unsigned nd;
      logic        x;
      f.bits = '0;
      f.n    = 0;
      x      = 1'b0;
      nd     = 5 + int'(wl);
      f.bits[f.n] = 1'b0;
      f.n++;
      for (int unsigned i = 0; i < nd; i++) begin
         f.bits[f.n] = d[i];
         x = x ^ d[i];
         f.n++;
      end
      if (pe) begin
         f.bits[f.n] = st ? ~ev : (ev ? x : ~x);
         f.n++;
      end
      f.bits[f.n] = 1'b1;
      f.n++;
      if (s2) begin
         f.bits[f.n] = 1'b1;
         f.n++;
      end
      return f;
   endfunction

   // Enable generator: one pulse every en_period cycles, frozen by en_pause.
   initial begin
      enable_i = 1'b0;
      forever begin
         @(negedge clk);
         if (en_pause) begin
            enable_i = 1'b0;
         end else begin
            enable_i = (en_cnt == 0);
            en_cnt   = (en_cnt + 1) % en_period;
         end
      end
   end

   task automatic wait_en(input int unsigned k);
      int unsigned seen = 0;
      while (seen < k) begin
         @(posedge clk);
         if (enable_i) seen++;
      end
   endtask

   // Line monitor.
   initial begin
      frame_t      f;
      int unsigned st;
      forever begin
         @(negedge clk);
         if (mon_en && rst_i && !stx_o) begin
            st       = cyc;
            last_gap = st - last_end_cyc;
            check_val("sb_has_frame", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               f = sb.pop_front();
               for (int unsigned i = 0; i < f.n; i++) begin
                  wait_en(8);
                  @(negedge clk);
                  check_val($sformatf("bit%0d", i), 32'(stx_o), 32'(f.bits[i]));
                  wait_en(8);
               end
               @(negedge clk);
               check_val("end_idle_line", 32'(stx_o), 32'd1);
               check_val("end_not_busy", 32'(busy_o), 32'd0);
               last_len     = cyc - st;
               last_end_cyc = cyc;
               frames_done++;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit push);
      int unsigned n = 0;
      tx_dat_i   = d;
      tx_valid_i = 1'b1;
      while (!tx_ready_o && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_val("send_ready", 32'(tx_ready_o), 32'd1);
      if (push) sb.push_back(make_frame(d, wlen_i, par_en_i, par_even_i, par_stick_i, stop2_i));
      @(posedge clk);
      @(negedge clk);
      tx_valid_i = 1'b0;
   endtask

   task automatic wait_busy(input int unsigned limit);
      int unsigned n = 0;
      while (!busy_o && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_val("busy_rise", 32'(busy_o), 32'd1);
   endtask

   task automatic wait_done(input int unsigned target, input int unsigned limit);
      int unsigned n = 0;
      while (frames_done < target && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_val("frames_done", frames_done, target);
   endtask

   task automatic set_period(input int unsigned p);
      @(posedge clk);
      #1 en_period = p;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        s0, b0, changed, low_bad;
      int unsigned n;

      rst_i       = 1'b0;
      wlen_i      = 2'b11;
      stop2_i     = 1'b0;
      par_en_i    = 1'b0;
      par_even_i  = 1'b0;
      par_stick_i = 1'b0;
      break_i     = 1'b0;
      tx_dat_i    = '0;
      tx_valid_i  = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_stx", 32'(stx_o), 32'd1);
      check_val("rst_ready", 32'(tx_ready_o), 32'd1);
      check_val("rst_busy", 32'(busy_o), 32'd0);
      check_val("rst_empty", 32'(tx_empty_o), 32'd1);
      rst_i = 1'b1;
      @(negedge clk);

      // 8N1 0x55
      send(8'h55, 1'b1);
      wait_done(1, 400);
      check_val("t1_len", last_len, 32'd160);
      check_val("t1_empty", 32'(tx_empty_o), 32'd1);

      // 5 bits, even parity, 2 stop, 0xE3; controls changed mid-character
      wlen_i = 2'b00; par_en_i = 1'b1; par_even_i = 1'b1; stop2_i = 1'b1;
      send(8'hE3, 1'b1);
      wait_busy(100);
      wlen_i = 2'b11; par_en_i = 1'b0; stop2_i = 1'b0; par_even_i = 1'b0;
      wait_done(2, 400);
      check_val("t2_len", last_len, 32'd144);

      // Back-to-back 0x41, 0x42
      send(8'h41, 1'b1);
      check_val("t3_ready_before_start", 32'(tx_ready_o), 32'd0);
      check_val("t3_idle_before_start", 32'(busy_o), 32'd0);
      wait_busy(100);
      repeat (24) @(negedge clk);
      send(8'h42, 1'b1);
      check_val("t3_ready_held", 32'(tx_ready_o), 32'd0);
      check_val("t3_busy_in_data", 32'(busy_o), 32'd1);
      wait_done(4, 800);
      check_val("t3_gap", last_gap, 32'd1);
      check_val("t3_len", last_len, 32'd160);

      // One enable every 4 cycles
      set_period(4);
      @(negedge clk);
      send(8'h3C, 1'b1);
      wait_done(5, 1500);
      check_val("t4_len", last_len, 32'd640);

      // Pause enable for 100 cycles mid-DATA
      send(8'hC3, 1'b1);
      wait_busy(50);
      repeat ((16 + 32 + 8) * 4) @(negedge clk);
      @(posedge clk);
      #1 en_pause = 1'b1;
      @(negedge clk);
      s0 = stx_o;
      b0 = busy_o;
      changed = 1'b0;
      repeat (99) begin
         @(negedge clk);
         if (stx_o !== s0 || busy_o !== b0) changed = 1'b1;
      end
      @(posedge clk);
      #1 en_pause = 1'b0;
      check_val("t4_pause_hold", 32'(changed), 32'd0);
      check_val("t4_pause_busy", 32'(b0), 32'd1);
      wait_done(6, 2000);
      check_val("t4_pause_len", last_len, 32'd740);
      set_period(1);
      @(negedge clk);

      // Reset mid-DATA of 0xA5, then 0x0F
      mon_en = 1'b0;
      send(8'hA5, 1'b0);
      wait_busy(100);
      repeat (72) @(negedge clk);
      check_val("t5_busy_pre", 32'(busy_o), 32'd1);
      check_val("t5_line_pre", 32'(stx_o), 32'd0);
      #2 rst_i = 1'b0;
      #1;
      check_val("t5_rst_stx", 32'(stx_o), 32'd1);
      check_val("t5_rst_ready", 32'(tx_ready_o), 32'd1);
      check_val("t5_rst_busy", 32'(busy_o), 32'd0);
      check_val("t5_rst_empty", 32'(tx_empty_o), 32'd1);
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      send(8'h0F, 1'b1);
      wait_done(7, 400);
      check_val("t5_len", last_len, 32'd160);

      // Odd stick parity, 0x00
      par_en_i = 1'b1; par_even_i = 1'b0; par_stick_i = 1'b1;
      send(8'h00, 1'b1);
      wait_done(8, 400);
      check_val("t6_len", last_len, 32'd176);

      // Break held across 0xFF
      par_en_i = 1'b0; par_stick_i = 1'b0;
      mon_en  = 1'b0;
      break_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_val("t7_break_idle", 32'(stx_o), 32'd0);
      send(8'hFF, 1'b0);
      wait_busy(100);
      n = 0;
      low_bad = 1'b0;
      while (busy_o && n < 400) begin
         if (stx_o !== 1'b0) low_bad = 1'b1;
         n++;
         @(negedge clk);
      end
      check_val("t7_break_low", 32'(low_bad), 32'd0);
      check_val("t7_busy_cycles", n, 32'd160);
      check_val("t7_busy_end", 32'(busy_o), 32'd0);
      break_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("t7_release", 32'(stx_o), 32'd1);
      check_val("t7_sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
